// File: rtl/radio_seq_ctrl_pkg.sv
// Shared definitions for the BT radio front-end sequencer: FSM states,
// bit timing and window width, and the latched direction encoding.
package bt_radio_pkg;

  localparam int BIT_CLKS = 6;
  localparam int LEN_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam logic DIR_TX = 1'b1;
  localparam logic DIR_RX = 1'b0;

endpackage

// File: rtl/radio_seq_ctrl_if.sv
// Link-controller <-> radio sequencer bundle: one-shot requests with their
// parameters in one direction, radio controls and status in the other.
interface radio_seq_ctrl_if #(
  parameter int LEN_W = bt_radio_pkg::LEN_W
);

  logic             tx_req_p;
  logic             rx_req_p;
  logic             abort_p;
  logic [6:0]       req_k;
  logic [LEN_W-1:0] req_len;
  logic [9:0]       regi_pllsetuptime;
  logic [6:0]       fk;
  logic             loadfreq_p;
  logic             txen;
  logic             rxen;
  logic             bit_p;
  logic             busy;
  logic             done_p;
  logic             drop_p;

  modport master (
    output tx_req_p, rx_req_p, abort_p, req_k, req_len, regi_pllsetuptime,
    input  fk, loadfreq_p, txen, rxen, bit_p, busy, done_p, drop_p
  );

  modport slave (
    input  tx_req_p, rx_req_p, abort_p, req_k, req_len, regi_pllsetuptime,
    output fk, loadfreq_p, txen, rxen, bit_p, busy, done_p, drop_p
  );

endinterface

// File: rtl/radio_seq_ctrl_bit_tick_gen.sv
// Bit-period phase counter. o_end flags the last clock of a bit; o_bit_p is
// registered so it lines up with the sequencer's registered enables.
module bit_tick_gen #(
  parameter int BIT_CLKS = bt_radio_pkg::BIT_CLKS
) (
  input  logic clk_6M,
  input  logic rst,
  input  logic i_clr,
  input  logic i_win,
  output logic o_bit_p,
  output logic o_end
);

  logic [2:0] r_phase;
  logic [2:0] w_phase_nx;
  logic       r_bit_p;

  assign o_end   = (r_phase == 3'(BIT_CLKS - 1));
  assign o_bit_p = r_bit_p;

  // next phase: cleared outside a timed state, wraps at the end of each bit
  always_comb begin
    w_phase_nx = r_phase;
    if (i_clr) begin
      w_phase_nx = 3'd0;
    end else if (o_end) begin
      w_phase_nx = 3'd0;
    end else begin
      w_phase_nx = r_phase + 3'd1;
    end
  end

  // phase register and bit strobe for the cycle that follows
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      r_phase <= 3'd0;
      r_bit_p <= 1'b0;
    end else begin
      r_phase <= w_phase_nx;
      r_bit_p <= i_win && (w_phase_nx == 3'd0);
    end
  end

endmodule

// File: rtl/radio_seq_ctrl.sv
// Radio front-end sequencer: arbitrates TX/RX slot requests, loads the hop
// frequency, waits out PLL settling and drives the enable window.
module radio_seq_ctrl #(
  parameter int BIT_CLKS = bt_radio_pkg::BIT_CLKS,
  parameter int LEN_W    = bt_radio_pkg::LEN_W
) (
  input  logic             clk_6M,
  input  logic             rst,
  radio_seq_ctrl_if.slave  bus
);

  import bt_radio_pkg::state_e;
  import bt_radio_pkg::ST_IDLE;
  import bt_radio_pkg::ST_LOAD;
  import bt_radio_pkg::ST_SETTLE;
  import bt_radio_pkg::ST_ACTIVE;
  import bt_radio_pkg::DIR_TX;
  import bt_radio_pkg::DIR_RX;

  state_e           r_state;
  state_e           w_state_nx;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nx;
  logic [LEN_W-1:0] r_len;
  logic [9:0]       r_pll;
  logic [6:0]       r_fk;
  logic             r_dir;
  logic             w_req;
  logic             w_accept;
  logic             w_drop;
  logic             w_done;
  logic             w_end;
  logic             w_clr;
  logic             w_win;
  logic             r_loadfreq_p;
  logic             r_txen;
  logic             r_rxen;
  logic             r_busy;
  logic             r_done_p;
  logic             r_drop_p;

  assign w_req = bus.tx_req_p || bus.rx_req_p;
  assign w_win = (w_state_nx == ST_ACTIVE);
  // the phase only keeps running while staying inside SETTLE/ACTIVE
  assign w_clr = !((r_state inside {ST_SETTLE, ST_ACTIVE}) &&
                   (w_state_nx inside {ST_SETTLE, ST_ACTIVE}));

  bit_tick_gen #(.BIT_CLKS(BIT_CLKS)) u_tick (
    .clk_6M  (clk_6M),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_win   (w_win),
    .o_bit_p (bus.bit_p),
    .o_end   (w_end)
  );

  // next-state, down-counter and pulse decode
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    w_drop     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !bus.abort_p) begin
          w_accept   = 1'b1;
          w_state_nx = ST_LOAD;
          w_drop     = bus.tx_req_p && bus.rx_req_p;
        end else begin
          w_drop = w_req;
        end
      end
      ST_LOAD: begin
        w_drop = w_req;
        if (bus.abort_p) begin
          w_state_nx = ST_IDLE;
        end else if (r_pll != 10'd0) begin
          w_state_nx = ST_SETTLE;
          w_cnt_nx   = LEN_W'(r_pll);
        end else if (r_len != {LEN_W{1'b0}}) begin
          w_state_nx = ST_ACTIVE;
          w_cnt_nx   = r_len;
        end else begin
          w_state_nx = ST_IDLE;
          w_done     = 1'b1;
        end
      end
      ST_SETTLE: begin
        w_drop = w_req;
        if (bus.abort_p) begin
          w_state_nx = ST_IDLE;
        end else if (w_end && (r_cnt <= LEN_W'(1'b1))) begin
          if (r_len != {LEN_W{1'b0}}) begin
            w_state_nx = ST_ACTIVE;
            w_cnt_nx   = r_len;
          end else begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = {LEN_W{1'b0}};
            w_done     = 1'b1;
          end
        end else if (w_end) begin
          w_cnt_nx = r_cnt - LEN_W'(1'b1);
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      ST_ACTIVE: begin
        w_drop = w_req;
        if (bus.abort_p) begin
          w_state_nx = ST_IDLE;
        end else if (w_end && (r_cnt <= LEN_W'(1'b1))) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = {LEN_W{1'b0}};
          w_done     = 1'b1;
        end else if (w_end) begin
          w_cnt_nx = r_cnt - LEN_W'(1'b1);
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // state, latched request and registered radio outputs
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {LEN_W{1'b0}};
      r_len        <= {LEN_W{1'b0}};
      r_pll        <= 10'd0;
      r_fk         <= 7'd0;
      r_dir        <= DIR_RX;
      r_loadfreq_p <= 1'b0;
      r_txen       <= 1'b0;
      r_rxen       <= 1'b0;
      r_busy       <= 1'b0;
      r_done_p     <= 1'b0;
      r_drop_p     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_fk  <= bus.req_k;
        r_len <= bus.req_len;
        r_pll <= bus.regi_pllsetuptime;
        r_dir <= bus.tx_req_p ? DIR_TX : DIR_RX;
      end
      r_loadfreq_p <= (w_state_nx == ST_LOAD);
      r_txen       <= w_win && (r_dir == DIR_TX);
      r_rxen       <= w_win && (r_dir == DIR_RX);
      r_busy       <= (w_state_nx != ST_IDLE);
      r_done_p     <= w_done;
      r_drop_p     <= w_drop;
    end
  end

  assign bus.fk         = r_fk;
  assign bus.loadfreq_p = r_loadfreq_p;
  assign bus.txen       = r_txen;
  assign bus.rxen       = r_rxen;
  assign bus.busy       = r_busy;
  assign bus.done_p     = r_done_p;
  assign bus.drop_p     = r_drop_p;

endmodule

// File: tb/tb_radio_seq_ctrl.sv
// Scoreboard bench for radio_seq_ctrl: stimulus queues expected output events
// (cycle, kind, value); a monitor pops and compares each event the DUT shows.
module tb_radio_seq_ctrl;

  localparam int K_DROP = 0;
  localparam int K_LOAD = 1;
  localparam int K_TXR  = 2;
  localparam int K_RXR  = 3;
  localparam int K_TXF  = 4;
  localparam int K_RXF  = 5;
  localparam int K_DONE = 6;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  ev_t  exp_q[$];

  radio_seq_ctrl_if #(.LEN_W(12)) bus ();

  radio_seq_ctrl dut (
    .clk_6M (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // keep the queue ordered by cycle, then by the monitor's per-cycle order
  task automatic push(input int c, input int kind, input int val);
    ev_t e;
    int  i;
    e.cyc = c; e.kind = kind; e.val = val;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind)))
      i++;
    exp_q.insert(i, e);
  endtask

  task automatic match(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: unexpected kind=%0d val=%0d at cycle %0d", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  task automatic run_monitor();
    logic p_tx, p_rx;
    int   bits;
    p_tx = 1'b0; p_rx = 1'b0; bits = 0;
    forever begin
      @(negedge clk);
      if (bus.bit_p) bits++;
      if (bus.drop_p) match(K_DROP, 0);
      if (bus.loadfreq_p) match(K_LOAD, int'(bus.fk) + (bus.busy ? 128 : 0));
      if (bus.txen && !p_tx) match(K_TXR, 0);
      if (bus.rxen && !p_rx) match(K_RXR, 0);
      if (!bus.txen && p_tx) begin match(K_TXF, bits); bits = 0; end
      if (!bus.rxen && p_rx) begin match(K_RXF, bits); bits = 0; end
      if (bus.done_p) match(K_DONE, int'(bus.fk) + (bus.busy ? 128 : 0));
      if (bus.txen && bus.rxen) check("txen_rxen_exclusive", 1, 0);
      p_tx = bus.txen;
      p_rx = bus.rxen;
    end
  endtask

  task automatic send(input logic tx, input logic rx, input logic ab, input int k,
                      input int len, input int pll, output int c0);
    logic [31:0] len_v, pll_v;
    len_v = len; pll_v = pll;
    @(negedge clk);
    bus.tx_req_p          = tx;
    bus.rx_req_p          = rx;
    bus.abort_p           = ab;
    bus.req_k             = 7'(k);
    bus.req_len           = len_v[11:0];
    bus.regi_pllsetuptime = pll_v[9:0];
    c0 = cyc;
    @(posedge clk);
    #1;
    bus.tx_req_p = 1'b0;
    bus.rx_req_p = 1'b0;
    bus.abort_p  = 1'b0;
  endtask

  task automatic expect_window(input int c0, input logic dir, input int k,
                               input int p, input int l);
    int s;
    s = c0 + 2 + 6 * p;
    push(c0 + 1, K_LOAD, k + 128);
    if (l != 0) begin
      push(s, dir ? K_TXR : K_RXR, 0);
      push(s + 6 * l, dir ? K_TXF : K_RXF, l);
    end
    push(s + 6 * l, K_DONE, k);
  endtask

  task automatic goto(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  int c0, c1, s;

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus.tx_req_p = 1'b0; bus.rx_req_p = 1'b0; bus.abort_p = 1'b0;
    bus.req_k = 7'd0; bus.req_len = 12'd0; bus.regi_pllsetuptime = 10'd0;
    fork run_monitor(); join_none
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.fk, bus.loadfreq_p, bus.txen, bus.rxen, bus.bit_p,
                                 bus.busy, bus.done_p, bus.drop_p}), 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // TX P=150 L=68 k=40
    send(1'b1, 1'b0, 1'b0, 40, 68, 150, c0);
    expect_window(c0, 1'b1, 40, 150, 68);
    wait_idle(2000);

    // simultaneous TX/RX, TX wins
    send(1'b1, 1'b1, 1'b0, 5, 1, 0, c0);
    push(c0 + 1, K_DROP, 0);
    expect_window(c0, 1'b1, 5, 0, 1);
    wait_idle(100);

    // RX request during TX settle is dropped, TX and fk untouched
    send(1'b1, 1'b0, 1'b0, 77, 10, 150, c0);
    expect_window(c0, 1'b1, 77, 150, 10);
    goto(c0 + 399);
    send(1'b0, 1'b1, 1'b0, 99, 3, 0, c1);
    push(c0 + 401, K_DROP, 0);
    wait_idle(2000);

    // abort during bit 10 of an RX window
    send(1'b0, 1'b1, 1'b0, 12, 30, 1, c0);
    s = c0 + 8;
    push(c0 + 1, K_LOAD, 12 + 128);
    push(s, K_RXR, 0);
    push(s + 63, K_RXF, 11);
    goto(s + 61);
    send(1'b0, 1'b0, 1'b1, 0, 0, 0, c1);
    @(negedge clk);
    check("abort_busy_low", int'({bus.busy, bus.rxen}), 0);
    wait_idle(100);
    send(1'b1, 1'b0, 1'b0, 3, 2, 0, c0);
    expect_window(c0, 1'b1, 3, 0, 2);
    wait_idle(100);

    // abort in IDLE together with a request
    send(1'b1, 1'b0, 1'b1, 1, 4, 4, c0);
    push(c0 + 1, K_DROP, 0);
    wait_idle(50);

    // P=0 L=0
    send(1'b1, 1'b0, 1'b0, 9, 0, 0, c0);
    expect_window(c0, 1'b1, 9, 0, 0);
    wait_idle(50);

    // back-to-back: next request in the done_p cycle
    send(1'b1, 1'b0, 1'b0, 20, 1, 0, c0);
    expect_window(c0, 1'b1, 20, 0, 1);
    goto(c0 + 7);
    send(1'b0, 1'b1, 1'b0, 21, 1, 0, c1);
    check("b2b_req_cycle", c1, c0 + 8);
    expect_window(c1, 1'b0, 21, 0, 1);
    wait_idle(100);

    // async reset in the middle of an ACTIVE window
    send(1'b1, 1'b0, 1'b0, 50, 200, 2, c0);
    push(c0 + 1, K_LOAD, 50 + 128);
    push(c0 + 14, K_TXR, 0);
    goto(c0 + 513);
    @(posedge clk);
    push(c0 + 514, K_TXF, 84);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", int'({bus.fk, bus.loadfreq_p, bus.txen, bus.rxen, bus.bit_p,
                                       bus.busy, bus.done_p, bus.drop_p}), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    send(1'b1, 1'b0, 1'b0, 66, 4, 3, c0);
    expect_window(c0, 1'b1, 66, 3, 4);
    wait_idle(200);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
